axis_pixels_pack: RTL and testbench
===================================

AXIS_PIXELS_PACK -- requirements
Module: axis_pixels_pack

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  ROWS 8: output rows per block.
  WORD_WIDTH 8: bits per pixel word.
  TUSER_WIDTH 8: sideband user width.
  KH_MAX 3: maximum kernel height.
  IN_WORDS 4: pixel words per input beat.
  IM_SHIFT_REGS ROWS+KH_MAX-1: words per packed block.
  BITS_KH $clog2(KH_MAX+1): kh field width.
REQ-002 Ports (name, direction, width, meaning), one per line; one clock; reset is asynchronous and active-high:
  aclk in 1: clock.
  areset in 1: async active-high reset.
  cfg_valid in 1: block config valid.
  cfg_ready out 1: config accepted.
  cfg_kh in BITS_KH: kernel height for next block.
  cfg_ones in 1: ones flag for next block.
  cfg_user in TUSER_WIDTH: user for next block.
  s_valid in 1: pixel beat valid.
  s_ready out 1: pixel beat accepted.
  s_data in IN_WORDS*WORD_WIDTH: pixel words, word 0 in LSBs.
  s_last in 1: last beat of block.
  m_valid out 1: packed block valid.
  m_ready in 1: downstream accepts.
  m_data out IM_SHIFT_REGS*WORD_WIDTH: packed block, word 0 in LSBs.
  m_shift out BITS_KH: kh-1, the shift count for the downstream shifter.
  m_ones out 1: ones flag.
  m_user out TUSER_WIDTH: user.
  err out 1: sticky framing/config error.

Function
REQ-003 Three-state FSM: IDLE, FILL, FULL.
REQ-004 IDLE: cfg_ready=1, s_ready=0; on cfg_valid, latch kh/ones/user, clear the word pointer and packing buffer, and go to FILL.
REQ-005 Effective kh: cfg_kh if 1..KH_MAX; otherwise KH_MAX, and err is set.
REQ-006 Block needs W=ROWS+kh-1 words over N=ceil(W/IN_WORDS) beats.
REQ-007 FILL: s_ready=1, cfg_ready=0; each accepted beat writes words ptr..ptr+IN_WORDS-1 into the buffer and advances ptr by IN_WORDS.
  Words at index >= W are discarded.
  Buffer words W..IM_SHIFT_REGS-1 remain zero.
REQ-008 FILL exit: on acceptance of beat N go to FULL regardless of s_last.
  If s_last is asserted on a beat other than beat N, or deasserted on beat N, err is set.
  Early s_last does not terminate the block.
REQ-009 FULL: s_ready=0, cfg_ready=0; when !m_valid or m_ready, copy buffer, kh-1, ones and user into the output register, set m_valid, and go to IDLE.
REQ-010 Latency: beat N accepted at edge T, block transferred at edge T+1 if the output register is free, m_valid high after edge T+1.
REQ-011 Output register holds m_data/m_shift/m_ones/m_user stable while m_valid & !m_ready.
  m_valid clears on m_ready unless a new transfer occurs in the same cycle.
REQ-012 Simultaneous m_ready and FULL transfer: the new block loads with no bubble and m_valid stays high.
REQ-013 Backpressure: with m_ready held low, at most one block waits in the output register and one in FULL; s_ready stays 0 until space frees.
REQ-014 No combinational path from m_ready to s_ready or cfg_ready; ready outputs derive from state only, plus m_valid in FULL.

Reset
REQ-015 Asserting areset asynchronously forces the following within the same cycle:
  state IDLE, ptr 0, buffer 0.
  m_valid 0, m_data/m_shift/m_ones/m_user 0, err 0.
  cfg_ready 1 after release, s_ready 0.
REQ-016 Reset during FILL or FULL discards the partial or pending block; no output is produced for it.

Configuration
REQ-017 Macro AXIS_PIXELS_PACK_ERR_EN:
  Defined: REQ-005/REQ-008 checks are active and err is sticky until reset.
  Undefined: check logic is omitted, err is tied 0, and out-of-range kh is still clamped to KH_MAX.

Verification
REQ-018 Directed scenarios, defaults, words numbered by stream order:
  - kh=3, three beats of words 0..11 with s_last on beat 3 -> one block, m_data words 0..9, m_shift=2, words 10,11 dropped, err=0.
  - kh=1, two beats of words 0..7 -> m_data words 0..7, words 8,9 zero, m_shift=0.
  - m_ready low; send two blocks (kh=3, user 0xA1 then 0xA2) -> first held stable, second waits in FULL with s_ready=0; raise m_ready -> 0xA1 then 0xA2 on back-to-back cycles.
  - cfg_kh=0 -> block packed as kh=3, err=1 (ERR_EN defined) or err=0 (undefined).
  - s_last on beat 2 of a kh=3 block -> block completes at beat 3, err=1.
  - areset pulsed after beat 2 -> no m_valid; next kh=2 block packs correctly with words from 0.

Source files
------------

// File: rtl/axis_pixels_pack.sv
`default_nettype none
// ============================================================================
// Module      : axis_pixels_pack
// Description : Packs a stream of multi-word pixel beats into one wide block
//               of ROWS+kh-1 words for a downstream shifter. A block config
//               (kh, ones, user) is taken first, then ceil(W/IN_WORDS) beats
//               are packed and handed to a one-deep output register.
//               Optional framing/config error flag: AXIS_PIXELS_PACK_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_pixels_pack #(
    parameter int ROWS          = 8,
    parameter int WORD_WIDTH    = 8,
    parameter int TUSER_WIDTH   = 8,
    parameter int KH_MAX        = 3,
    parameter int IN_WORDS      = 4,
    parameter int IM_SHIFT_REGS = ROWS + KH_MAX - 1,
    parameter int BITS_KH       = $clog2(KH_MAX + 1)
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic                                cfg_valid,
    output logic                                cfg_ready,
    input  logic [BITS_KH-1:0]                  cfg_kh,
    input  logic                                cfg_ones,
    input  logic [TUSER_WIDTH-1:0]              cfg_user,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [IN_WORDS*WORD_WIDTH-1:0]      s_data,
    input  logic                                s_last,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [IM_SHIFT_REGS*WORD_WIDTH-1:0] m_data,
    output logic [BITS_KH-1:0]                  m_shift,
    output logic                                m_ones,
    output logic [TUSER_WIDTH-1:0]              m_user,
    output logic                                err
);

    // Pointer must hold ptr+IN_WORDS for the last beat of the longest block.
    localparam int                 c_PTR_W  = $clog2(IM_SHIFT_REGS + IN_WORDS + 1);
    localparam logic [BITS_KH-1:0] c_KH_MAX = BITS_KH'(KH_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t                                      r_state;
    logic [c_PTR_W-1:0]                          r_ptr;
    logic [c_PTR_W-1:0]                          r_wlen;
    logic [IM_SHIFT_REGS-1:0][WORD_WIDTH-1:0]    r_buf;
    logic [BITS_KH-1:0]                          r_kh;
    logic                                        r_ones;
    logic [TUSER_WIDTH-1:0]                      r_user;
    logic                                        r_m_valid;
    logic [IM_SHIFT_REGS*WORD_WIDTH-1:0]         r_m_data;
    logic [BITS_KH-1:0]                          r_m_shift;
    logic                                        r_m_ones;
    logic [TUSER_WIDTH-1:0]                      r_m_user;

    logic                                        w_kh_ok;
    logic [BITS_KH-1:0]                          w_kh_eff;
    logic [c_PTR_W-1:0]                          w_wlen;
    logic [c_PTR_W-1:0]                          w_ptr_next;
    logic                                        w_last_beat;
    logic                                        w_out_free;

    // Out-of-range kh (0 or above KH_MAX) is clamped to the largest kernel.
    assign w_kh_ok     = (cfg_kh != '0) && (cfg_kh <= c_KH_MAX);
    assign w_kh_eff    = w_kh_ok ? cfg_kh : c_KH_MAX;
    assign w_wlen      = c_PTR_W'(ROWS) + c_PTR_W'(w_kh_eff) - c_PTR_W'(1);
    // The beat that reaches or passes the last needed word closes the block.
    assign w_ptr_next  = r_ptr + c_PTR_W'(IN_WORDS);
    assign w_last_beat = (w_ptr_next >= r_wlen);
    assign w_out_free  = !r_m_valid || m_ready;

    // Readies come from registered state only, so m_ready never reaches them.
    assign cfg_ready = (r_state == ST_IDLE);
    assign s_ready   = (r_state == ST_FILL);

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_shift = r_m_shift;
    assign m_ones  = r_m_ones;
    assign m_user  = r_m_user;

    // Block FSM together with the packing buffer and the output register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_wlen    <= '0;
            r_buf     <= '0;
            r_kh      <= '0;
            r_ones    <= 1'b0;
            r_user    <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_shift <= '0;
            r_m_ones  <= 1'b0;
            r_m_user  <= '0;
        end else begin
            if (m_ready) begin
                r_m_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        r_kh    <= w_kh_eff;
                        r_ones  <= cfg_ones;
                        r_user  <= cfg_user;
                        r_wlen  <= w_wlen;
                        r_ptr   <= '0;
                        r_buf   <= '0;
                        r_state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (s_valid) begin
                        // Word k of the beat lands at ptr+k; words past W are dropped.
                        for (int j = 0; j < IM_SHIFT_REGS; j++) begin
                            for (int k = 0; k < IN_WORDS; k++) begin
                                if ((r_ptr + c_PTR_W'(k) == c_PTR_W'(j)) &&
                                    (c_PTR_W'(j) < r_wlen)) begin
                                    r_buf[j] <= s_data[k*WORD_WIDTH +: WORD_WIDTH];
                                end
                            end
                        end
                        r_ptr <= w_ptr_next;
                        if (w_last_beat) begin
                            r_state <= ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (w_out_free) begin
                        r_m_valid <= 1'b1;
                        r_m_data  <= r_buf;
                        r_m_shift <= r_kh - BITS_KH'(1);
                        r_m_ones  <= r_ones;
                        r_m_user  <= r_user;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef AXIS_PIXELS_PACK_ERR_EN
    logic r_err;

    // Sticky flag: bad kh on config, or s_last not matching the final beat.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_err <= 1'b0;
        end else if ((r_state == ST_IDLE) && cfg_valid && !w_kh_ok) begin
            r_err <= 1'b1;
        end else if ((r_state == ST_FILL) && s_valid && (s_last != w_last_beat)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    // Framing is carried by the beat count alone; s_last is not inspected.
    logic w_unused_s_last;
    assign w_unused_s_last = s_last;
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_pixels_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_pixels_pack
// Description : Self-checking bench for axis_pixels_pack. Expected blocks are
//               built from the stream words and the block rules, queued, and
//               compared at each output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_pixels_pack;

    localparam int ROWS   = 8;
    localparam int WW     = 8;
    localparam int UW     = 8;
    localparam int KH_MAX = 3;
    localparam int INW    = 4;
    localparam int NREG   = ROWS + KH_MAX - 1;
    localparam int BKH    = $clog2(KH_MAX + 1);

    typedef struct {
        logic [NREG*WW-1:0] data;
        logic [BKH-1:0]     shift;
        logic               ones;
        logic [UW-1:0]      user;
    } blk_t;

    logic                 clk = 1'b0;
    logic                 areset;
    logic                 cfg_valid, cfg_ready, cfg_ones;
    logic [BKH-1:0]       cfg_kh;
    logic [UW-1:0]        cfg_user;
    logic                 s_valid, s_ready, s_last;
    logic [INW*WW-1:0]    s_data;
    logic                 m_valid, m_ready, m_ones, err;
    logic [NREG*WW-1:0]   m_data;
    logic [BKH-1:0]       m_shift;
    logic [UW-1:0]        m_user;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   rdy_mode = 1;        // 0: hold low, 1: hold high, 2: random
    int   cyc      = 0;
    bit   exp_err  = 1'b0;
    blk_t exp_q[$];
    int   xfer_cyc[$];

    axis_pixels_pack dut (
        .aclk      (clk),
        .areset    (areset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_kh    (cfg_kh),
        .cfg_ones  (cfg_ones),
        .cfg_user  (cfg_user),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_shift   (m_shift),
        .m_ones    (m_ones),
        .m_user    (m_user),
        .err       (err)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Output side: drive m_ready, score handshakes, verify hold stability.
    initial begin
        bit           held = 1'b0;
        logic [127:0] held_bus = '0;
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            case (rdy_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = (($urandom % 10) < 7);
            endcase
            if (held && !areset) begin
                check("hold_valid", 128'(m_valid), 128'(1));
                check("hold_bus", 128'({m_user, m_ones, m_shift, m_data}), held_bus);
            end
            held = 1'b0;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_xfer", 128'(m_valid), 128'(0));
                end else begin
                    blk_t e;
                    e = exp_q.pop_front();
                    check("m_data", 128'(m_data), 128'(e.data));
                    check("m_shift", 128'(m_shift), 128'(e.shift));
                    check("m_ones", 128'(m_ones), 128'(e.ones));
                    check("m_user", 128'(m_user), 128'(e.user));
                end
                xfer_cyc.push_back(cyc);
            end else if (m_valid) begin
                held     = 1'b1;
                held_bus = 128'({m_user, m_ones, m_shift, m_data});
            end
        end
    end

    task automatic do_cfg(input logic [BKH-1:0] kh, input logic ones, input logic [UW-1:0] user);
        int t = 0;
        cfg_kh = kh; cfg_ones = ones; cfg_user = user; cfg_valid = 1'b1;
        while (!cfg_ready && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) check("cfg_tmo", 128'(cfg_ready), 128'(1));
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [INW*WW-1:0] d, input logic last);
        int t = 0;
        s_data = d; s_last = last; s_valid = 1'b1;
        while (!s_ready && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) check("beat_tmo", 128'(s_ready), 128'(1));
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    // One whole block; last_pos 0 means s_last on the proper final beat.
    task automatic run_block(input int kh_cfg, input logic ones, input logic [UW-1:0] user,
                             input int last_pos, input bit seq, input bit gaps);
        int          kh, w, n;
        logic [WW-1:0] words[$];
        blk_t        e;
        logic [INW*WW-1:0] beat;
        kh = (kh_cfg >= 1 && kh_cfg <= KH_MAX) ? kh_cfg : KH_MAX;
        w  = ROWS + kh - 1;
        n  = (w + INW - 1) / INW;
        if (last_pos == 0) last_pos = n;
        for (int i = 0; i < n * INW; i++) words.push_back(seq ? WW'(i) : WW'($urandom));
        e.data = '0;
        for (int i = 0; i < w; i++) e.data[i*WW +: WW] = words[i];
        e.shift = BKH'(kh - 1);
        e.ones  = ones;
        e.user  = user;
        exp_q.push_back(e);
`ifdef AXIS_PIXELS_PACK_ERR_EN
        if (kh != kh_cfg || last_pos != n) exp_err = 1'b1;
`endif
        do_cfg(BKH'(kh_cfg), ones, user);
        for (int b = 1; b <= n; b++) begin
            if (gaps) repeat ($urandom % 3) @(negedge clk);
            for (int k = 0; k < INW; k++) beat[k*WW +: WW] = words[(b-1)*INW + k];
            send_beat(beat, b == last_pos);
        end
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((exp_q.size() != 0 || m_valid) && t < 2000) begin @(negedge clk); t++; end
        if (t >= 2000) check(tag, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        areset = 1'b1; cfg_valid = 1'b0; cfg_kh = '0; cfg_ones = 1'b0; cfg_user = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_m_valid", 128'(m_valid), 128'(0));
        check("rst_s_ready", 128'(s_ready), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        check("rst_m_data", 128'(m_data), 128'(0));
        check("rst_m_shift", 128'(m_shift), 128'(0));
        areset = 1'b0;
        @(negedge clk);
        check("rst_cfg_ready", 128'(cfg_ready), 128'(1));

        // kh=3: words 0..9 kept, 10,11 dropped.
        run_block(3, 1'b1, 8'h11, 0, 1'b1, 1'b0);
        drain("drain_kh3");
        check("kh3_err", 128'(err), 128'(exp_err));

        // kh=1: words 0..7, upper two words zero.
        run_block(1, 1'b0, 8'h22, 0, 1'b1, 1'b0);
        drain("drain_kh1");

        // Backpressure: first block held, second parked in FULL.
        rdy_mode = 0;
        run_block(3, 1'b0, 8'hA1, 0, 1'b1, 1'b0);
        run_block(3, 1'b1, 8'hA2, 0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("bp_m_valid", 128'(m_valid), 128'(1));
        check("bp_m_user", 128'(m_user), 128'(8'hA1));
        check("bp_s_ready", 128'(s_ready), 128'(0));
        check("bp_cfg_ready", 128'(cfg_ready), 128'(0));
        xfer_cyc.delete();
        rdy_mode = 1;
        drain("drain_bp");
        check("bp_xfers", 128'(xfer_cyc.size()), 128'(2));
        if (xfer_cyc.size() == 2)
            check("bp_back2back", 128'(xfer_cyc[1] - xfer_cyc[0]), 128'(1));

        // cfg_kh=0 clamps to kh=3.
        run_block(0, 1'b1, 8'h33, 0, 1'b1, 1'b0);
        drain("drain_kh0");
        check("kh0_err", 128'(err), 128'(exp_err));

        // Reset mid-block: nothing emitted, flags cleared.
        do_cfg(2'd3, 1'b0, 8'h44);
        send_beat(32'h03020100, 1'b0);
        send_beat(32'h07060504, 1'b0);
        areset = 1'b1;
        #1;
        check("arst_s_ready", 128'(s_ready), 128'(0));
        check("arst_m_valid", 128'(m_valid), 128'(0));
        check("arst_err", 128'(err), 128'(0));
        @(negedge clk);
        areset = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
        check("arst_cfg_ready", 128'(cfg_ready), 128'(1));
        repeat (3) @(negedge clk);
        check("arst_no_out", 128'(m_valid), 128'(0));
        run_block(2, 1'b0, 8'h55, 0, 1'b1, 1'b0);
        drain("drain_kh2");
        check("kh2_err", 128'(err), 128'(0));

        // Early s_last on beat 2 of a three-beat block.
        run_block(3, 1'b0, 8'h66, 2, 1'b1, 1'b0);
        drain("drain_early");
        check("early_err", 128'(err), 128'(exp_err));

        // Randomized traffic with random backpressure and input gaps.
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            run_block(int'($urandom % 4), 1'($urandom), UW'($urandom),
                      (($urandom % 6) == 0) ? 1 : 0, 1'b0, 1'b1);
            check("rand_err", 128'(err), 128'(exp_err));
        end
        rdy_mode = 1;
        drain("drain_rand");
        check("final_queue", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
